// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller: syncs received bytes into clk,
// decodes cmd+addr / data frames, and serves a config register bank.
module spi_reg_ctrl #(
  parameter int         NUM_REGS    = 16,
  parameter int         TIMEOUT     = 50000,
  parameter logic [6:0] STATUS_ADDR = 7'h7F
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  input  logic [7:0]            status_in,
  output logic [8*NUM_REGS-1:0] cfg_regs,
  output logic                  wr_stb,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  err_stb,
  output logic                  busy
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = ($clog2(TIMEOUT) > 16) ? $clog2(TIMEOUT) : 16;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    NREGS = 8'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_DUMMY
  } state_e;

  state_e         state_q;
  logic [2:0]     sync_q;
  logic [1:0]     arm_q;
  logic           armed_q;
  logic           evt_q;
  logic [6:0]     addr_q;
  logic [TW-1:0]  cnt_q;
  logic [7:0]     tx_q;
  logic           wr_stb_q;
  logic           err_stb_q;
  logic [6:0]     wr_addr_q;
  logic [7:0]     wr_data_q;
  logic [7:0]     regs_q [NUM_REGS];

  logic           cmd_in_rng;
  logic           cmd_is_stat;
  logic           addr_in_rng;
  logic           tmo;
  logic [7:0]     rd_val;

  // Edge detect is held off until rx_valid has been seen low once,
  // so a byte already in flight at reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      arm_q   <= '0;
      armed_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rx_valid};
      arm_q   <= {arm_q[0], 1'b1};
      armed_q <= armed_q | (arm_q[1] & ~sync_q[1]);
      evt_q   <= armed_q & sync_q[1] & ~sync_q[2];
    end
  end

  assign cmd_in_rng  = {1'b0, rx_data[6:0]} < NREGS;
  assign cmd_is_stat = rx_data[6:0] == STATUS_ADDR;
  assign addr_in_rng = {1'b0, addr_q} < NREGS;
  assign tmo         = cnt_q == TLAST;

  always_comb begin
    rd_val = 8'h00;
    unique case (1'b1)
      cmd_in_rng:  rd_val = regs_q[rx_data[AW-1:0]];
      cmd_is_stat: rd_val = status_in;
      default:     rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      tx_q      <= 8'h00;
      wr_stb_q  <= 1'b0;
      err_stb_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      wr_stb_q  <= 1'b0;
      err_stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (evt_q) begin
            addr_q <= rx_data[6:0];
            cnt_q  <= '0;
            if (rx_data[7]) begin
              state_q   <= RD_DUMMY;
              tx_q      <= rd_val;
              err_stb_q <= !cmd_in_rng && !cmd_is_stat;
            end else begin
              state_q <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (evt_q) begin
            state_q <= IDLE;
            if (addr_in_rng) begin
              regs_q[addr_q[AW-1:0]] <= rx_data;
              wr_stb_q  <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= rx_data;
            end else begin
              err_stb_q <= 1'b1;
            end
          end else if (tmo) begin
            state_q   <= IDLE;
            tx_q      <= 8'h00;
            err_stb_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        RD_DUMMY: begin
          if (evt_q) begin
            state_q <= IDLE;
            tx_q    <= 8'h00;
          end else if (tmo) begin
            state_q   <= IDLE;
            tx_q      <= 8'h00;
            err_stb_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bank
    assign cfg_regs[8*i +: 8] = regs_q[i];
  end

  assign tx_data = tx_q;
  assign wr_stb  = wr_stb_q;
  assign err_stb = err_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = state_q != IDLE;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: frames, status, range errors,
// timeout, byte/timeout collision and reset behaviour.
module tb_spi_reg_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic [7:0]   status_in;
  logic [127:0] cfg_regs;
  logic         wr_stb;
  logic [6:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         err_stb;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  logic [127:0] exp_bank = '0;

  spi_reg_ctrl #(
    .NUM_REGS(16),
    .TIMEOUT(100),
    .STATUS_ADDR(7'h7F)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .status_in(status_in),
    .cfg_regs(cfg_regs),
    .wr_stb(wr_stb),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .err_stb(err_stb),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) wr_cnt++;
    if (err_stb) err_cnt++;
  end

  // got = what the core would load into din just before this byte
  task automatic send_byte(input logic [7:0] b, output logic [7:0] got);
    @(negedge clk);
    got = tx_data;
    rx_data = b;
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1,
                       output logic [7:0] got);
    logic [7:0] dummy;
    send_byte(b0, dummy);
    send_byte(b1, got);
  endtask

  // raise rx_valid for a command byte and wait for busy; k = cycles waited
  task automatic start_cmd(input logic [7:0] b, output int k);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    k = 0;
    while (!busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!busy) begin
      errors++;
      $display("FAIL cmd_busy: busy=%0b after %0d cycles, required 1", busy, k);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_tx: got %h required 00", tx_data);
    end
    checks++;
    if ({busy, wr_stb, err_stb} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags: busy/wr/err=%b required 000", {busy, wr_stb, err_stb});
    end
    checks++;
    if ({wr_addr, wr_data} !== 15'h0) begin
      errors++;
      $display("FAIL rst_wr: addr=%h data=%h required 0/0", wr_addr, wr_data);
    end
    checks++;
    if (cfg_regs !== 128'h0) begin
      errors++;
      $display("FAIL rst_bank: got %h required 0", cfg_regs);
    end
  endtask

  task automatic test_write_read;
    int w0, e0;
    logic [7:0] got;
    w0 = wr_cnt;
    e0 = err_cnt;
    frame(8'h03, 8'h5A, got);
    exp_bank[31:24] = 8'h5A;
    checks++;
    if (wr_cnt - w0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL wr_pulses: wr=%0d err=%0d required 1/0", wr_cnt - w0, err_cnt - e0);
    end
    checks++;
    if (wr_addr !== 7'd3 || wr_data !== 8'h5A) begin
      errors++;
      $display("FAIL wr_addr_data: %h/%h required 03/5a", wr_addr, wr_data);
    end
    checks++;
    if (cfg_regs !== exp_bank) begin
      errors++;
      $display("FAIL wr_bank: got %h required %h", cfg_regs, exp_bank);
    end
    frame(8'h83, 8'h00, got);
    checks++;
    if (got !== 8'h5A) begin
      errors++;
      $display("FAIL rd_data: got %h required 5a", got);
    end
    checks++;
    if (tx_data !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_after: tx=%h busy=%b required 00/0", tx_data, busy);
    end
  endtask

  task automatic test_status;
    int w0, e0;
    logic [7:0] got;
    status_in = 8'hC3;
    e0 = err_cnt;
    frame(8'hFF, 8'h00, got);
    checks++;
    if (got !== 8'hC3 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL stat_rd: got %h err=%0d required c3/0", got, err_cnt - e0);
    end
    w0 = wr_cnt;
    e0 = err_cnt;
    frame(8'h7F, 8'h11, got);
    checks++;
    if (err_cnt - e0 !== 1 || wr_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL stat_wr: err=%0d wr=%0d required 1/0", err_cnt - e0, wr_cnt - w0);
    end
    checks++;
    if (cfg_regs !== exp_bank) begin
      errors++;
      $display("FAIL stat_bank: got %h required %h", cfg_regs, exp_bank);
    end
  endtask

  task automatic test_out_of_range;
    int w0, e0;
    logic [7:0] got;
    e0 = err_cnt;
    frame(8'h90, 8'h00, got);
    checks++;
    if (got !== 8'h00 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL oor_rd: got %h err=%0d required 00/1", got, err_cnt - e0);
    end
    w0 = wr_cnt;
    e0 = err_cnt;
    frame(8'h20, 8'h44, got);
    checks++;
    if (err_cnt - e0 !== 1 || wr_cnt - w0 !== 0 || cfg_regs !== exp_bank) begin
      errors++;
      $display("FAIL oor_wr: err=%0d wr=%0d bank=%h required 1/0/%h",
               err_cnt - e0, wr_cnt - w0, cfg_regs, exp_bank);
    end
  endtask

  task automatic test_timeout;
    int k, n, w0;
    logic [7:0] got;
    w0 = wr_cnt;
    start_cmd(8'h05, k);
    n = 0;
    while (!err_stb && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 3) rx_valid = 1'b0;
    end
    checks++;
    if (n !== 100) begin
      errors++;
      $display("FAIL tmo_delay: err_stb after %0d cycles, required 100", n);
    end
    checks++;
    if (busy !== 1'b0 || tx_data !== 8'h00 || wr_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL tmo_state: busy=%b tx=%h wr=%0d required 0/00/0",
               busy, tx_data, wr_cnt - w0);
    end
    rx_valid = 1'b0;
    repeat (8) @(negedge clk);
    frame(8'h05, 8'h77, got);
    exp_bank[47:40] = 8'h77;
    checks++;
    if (wr_addr !== 7'd5 || wr_data !== 8'h77 || cfg_regs !== exp_bank) begin
      errors++;
      $display("FAIL tmo_recover: addr=%h data=%h bank=%h required 05/77/%h",
               wr_addr, wr_data, cfg_regs, exp_bank);
    end
  endtask

  task automatic test_collision;
    int k, e0;
    logic ws, es;
    e0 = err_cnt;
    start_cmd(8'h06, k);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 2) rx_valid = 1'b0;
      if (i == 96) begin
        rx_data = 8'hA6;
        rx_valid = 1'b1;
      end
    end
    ws = wr_stb;
    es = err_stb;
    exp_bank[55:48] = 8'hA6;
    checks++;
    if (ws !== 1'b1 || es !== 1'b0) begin
      errors++;
      $display("FAIL coll_pulse: wr_stb=%b err_stb=%b required 1/0", ws, es);
    end
    rx_valid = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (err_cnt - e0 !== 0 || cfg_regs !== exp_bank || busy !== 1'b0) begin
      errors++;
      $display("FAIL coll_after: err=%0d busy=%b bank=%h required 0/0/%h",
               err_cnt - e0, busy, cfg_regs, exp_bank);
    end
  endtask

  task automatic test_reset_mid;
    int k, w0, e0;
    logic [7:0] got;
    start_cmd(8'h02, k);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_bank = '0;
    test_reset();
    repeat (6) @(negedge clk);
    w0 = wr_cnt;
    e0 = err_cnt;
    frame(8'h99, 8'h00, got);
    checks++;
    if (got !== 8'h00 || err_cnt - e0 !== 1 || wr_cnt - w0 !== 0) begin
      errors++;
      $display("FAIL rstmid_cmd: got %h err=%0d wr=%0d required 00/1/0",
               got, err_cnt - e0, wr_cnt - w0);
    end
    checks++;
    if (cfg_regs[23:16] !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_reg2: reg2=%h busy=%b required 00/0", cfg_regs[23:16], busy);
    end
  endtask

  task automatic test_valid_high_at_reset;
    int e0;
    bit seen_busy;
    @(negedge clk);
    rst_n = 1'b0;
    rx_data = 8'h85;
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = err_cnt;
    seen_busy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    checks++;
    if (seen_busy !== 1'b0 || err_cnt - e0 !== 0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL hot_reset: busy=%b err=%0d tx=%h required 0/0/00",
               seen_busy, err_cnt - e0, tx_data);
    end
    rx_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    status_in = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    test_reset();
    test_write_read();
    test_status();
    test_out_of_range();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_valid_high_at_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
